// File: rtl/pipe_ifu_if.sv
// IF-stage bundle: flush/redirect control, instruction-memory request/response
// channels and the IF->ID valid/ready channel, seen from the IFU (master) side.
interface pipe_ifu_if;
   logic        flush_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_resp_valid_i;
   logic        imem_resp_ready_o;
   logic [31:0] imem_resp_data_i;
   logic        if_valid_o;
   logic        id_ready_i;
   logic [63:0] if_to_id_o;

   modport master (
      input  flush_i, redirect_pc_i,
      output imem_req_valid_o, imem_req_addr_o,
      input  imem_req_ready_i,
      input  imem_resp_valid_i, imem_resp_data_i,
      output imem_resp_ready_o,
      output if_valid_o, if_to_id_o,
      input  id_ready_i
   );

   modport slave (
      output flush_i, redirect_pc_i,
      input  imem_req_valid_o, imem_req_addr_o,
      output imem_req_ready_i,
      output imem_resp_valid_i, imem_resp_data_i,
      input  imem_resp_ready_o,
      input  if_valid_o, if_to_id_o,
      output id_ready_i
   );
endinterface

// File: rtl/pipe_ifu.sv
// Instruction-fetch stage: one outstanding imem request, buffers the response
// and presents {pc, inst} to decode; flush redirects and drops stale data.
module pipe_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   pipe_ifu_if.master  io
);

   typedef enum logic [1:0] {REQ, WAIT, OUT, DRAIN} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [63:0] buf_reg, buf_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= REQ;
         pc_reg    <= RESET_PC;
         buf_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         buf_reg   <= buf_next;
      end
   end

   // A response is only legal while a request is outstanding (WAIT/DRAIN).
   always_ff @(posedge clk_i) begin
      if (!rst_i && io.imem_resp_valid_i)
         assert (state_reg == WAIT || state_reg == DRAIN);
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      buf_next   = buf_reg;
      if (io.flush_i) begin
         pc_next = {io.redirect_pc_i[31:2], 2'b00};
         case (state_reg)
            REQ:         state_next = io.imem_req_ready_i ? DRAIN : REQ;
            WAIT, DRAIN: state_next = io.imem_resp_valid_i ? REQ : DRAIN;
            OUT: begin
               state_next = REQ;
               buf_next   = '0;
            end
            default:     state_next = REQ;
         endcase
      end else begin
         case (state_reg)
            REQ: begin
               if (io.imem_req_ready_i) state_next = WAIT;
            end
            WAIT: begin
               if (io.imem_resp_valid_i) begin
                  buf_next   = {pc_reg, io.imem_resp_data_i};
                  pc_next    = pc_reg + PC_STEP;
                  state_next = OUT;
               end
            end
            OUT: begin
               if (io.id_ready_i) state_next = REQ;
            end
            DRAIN: begin
               if (io.imem_resp_valid_i) state_next = REQ;
            end
            default: state_next = REQ;
         endcase
      end
   end

   assign io.imem_req_valid_o  = (state_reg == REQ);
   assign io.imem_req_addr_o   = (state_reg == REQ) ? pc_reg : 32'd0;
   assign io.imem_resp_ready_o = (state_reg == WAIT) || (state_reg == DRAIN);
   assign io.if_valid_o        = (state_reg == OUT);
   assign io.if_to_id_o        = (state_reg == OUT) ? buf_reg : 64'd0;

endmodule

// File: tb/tb_pipe_ifu.sv
// Randomized bench for pipe_ifu against a transaction-level fetch model
// (next-fetch PC, outstanding request, queue of instructions owed to decode).
module tb_pipe_ifu;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_ifu_if io();
   pipe_ifu #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .io    (io)
   );

   int n_checks = 0;
   int n_err    = 0;
   int n_xfer   = 0;
   bit armed    = 1'b0;

   // reference model state
   logic [31:0] exp_pc;
   bit          m_out;
   bit          m_stale;
   logic [31:0] m_pc;
   logic [63:0] q[$];
   // memory responder state
   bit          mem_pend;
   int          mem_cnt;
   logic [31:0] mem_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic settle;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input bit r, input bit f, input logic [31:0] rd, input bit rq,
                       input bit idr, input int lat, input logic [31:0] dat);
      bit req_hs, resp_hs, out_hs, rv;
      @(negedge clk);
      if (armed) begin
         check("req_valid", 64'(io.imem_req_valid_o), 64'(!m_out && q.size() == 0));
         if (io.imem_req_valid_o === 1'b1) check("req_addr", 64'(io.imem_req_addr_o), 64'(exp_pc));
         check("resp_ready", 64'(io.imem_resp_ready_o), 64'(m_out));
         check("if_valid", 64'(io.if_valid_o), 64'(q.size() != 0));
         if (q.size() != 0) check("if_to_id", io.if_to_id_o, q[0]);
         else               check("if_to_id_idle", io.if_to_id_o, 64'd0);
      end
      rv = mem_pend && (mem_cnt == 0);
      rst                  = r;
      io.flush_i           = f;
      io.redirect_pc_i     = rd;
      io.imem_req_ready_i  = rq;
      io.id_ready_i        = idr;
      io.imem_resp_valid_i = rv;
      io.imem_resp_data_i  = rv ? mem_data : 32'd0;
      req_hs  = (io.imem_req_valid_o === 1'b1) && rq;
      resp_hs = (io.imem_resp_ready_o === 1'b1) && rv;
      out_hs  = (io.if_valid_o === 1'b1) && idr;
      if (r) begin
         exp_pc   = RESET_PC;
         m_out    = 1'b0;
         m_stale  = 1'b0;
         q.delete();
         mem_pend = 1'b0;
         mem_cnt  = 0;
      end else begin
         if (resp_hs) begin
            if (!m_stale && !f) q.push_back({m_pc, mem_data});
            m_out    = 1'b0;
            mem_pend = 1'b0;
         end
         if (out_hs && !f && q.size() != 0) begin
            $display("xfer pc=%h inst=%h", q[0][63:32], q[0][31:0]);
            n_xfer++;
            void'(q.pop_front());
         end
         if (f) q.delete();
         if (f && m_out) m_stale = 1'b1;
         if (req_hs) begin
            m_out    = 1'b1;
            m_pc     = exp_pc;
            m_stale  = f;
            exp_pc   = exp_pc + 32'd4;
            mem_pend = 1'b1;
            mem_cnt  = lat;
            mem_data = dat;
         end else if (mem_pend && mem_cnt > 0) begin
            mem_cnt--;
         end
         if (f) exp_pc = {rd[31:2], 2'b00};
      end
   endtask

   task automatic to_out;
      for (int i = 0; i < 20; i++) begin
         if (q.size() != 0) return;
         step(0, 0, 32'd0, 1, 0, 0, $urandom);
      end
      check("to_out_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain_to_req;
      for (int i = 0; i < 20; i++) begin
         if (!m_out && q.size() == 0) return;
         step(0, 0, 32'd0, 0, 1, 0, $urandom);
      end
      check("drain_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] held;
      logic [31:0] rd;
      io.flush_i = 0; io.redirect_pc_i = 0; io.imem_req_ready_i = 0;
      io.id_ready_i = 0; io.imem_resp_valid_i = 0; io.imem_resp_data_i = 0;

      // reset, then 0-latency memory returning 0x13
      step(1, 0, 32'd0, 0, 0, 0, 32'd0);
      armed = 1'b1;
      settle;
      check("rst_req_valid", 64'(io.imem_req_valid_o), 64'd1);
      check("rst_req_addr", 64'(io.imem_req_addr_o), 64'(RESET_PC));
      check("rst_if_valid", 64'(io.if_valid_o), 64'd0);
      check("rst_resp_ready", 64'(io.imem_resp_ready_o), 64'd0);
      check("rst_if_to_id", io.if_to_id_o, 64'd0);
      for (int k = 1; k <= 9; k++) begin
         step(0, 0, 32'd0, 1, 1, 0, 32'h0000_0013);
         settle;
         check("t1_if_valid", 64'(io.if_valid_o), 64'((k + 1) % 3 == 0));
         if (k == 2) check("t1_first", io.if_to_id_o, {RESET_PC, 32'h0000_0013});
         if (k % 3 == 0) check("t1_addr", 64'(io.imem_req_addr_o), 64'(RESET_PC + 32'(4 * (k / 3))));
      end

      // decode stall for 5 cycles
      to_out;
      held = q[0];
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 32'd0, 1, 0, 0, $urandom);
         settle;
         check("t2_hold_valid", 64'(io.if_valid_o), 64'd1);
         check("t2_hold_data", io.if_to_id_o, held);
         check("t2_no_req", 64'(io.imem_req_valid_o), 64'd0);
      end
      step(0, 0, 32'd0, 0, 1, 0, $urandom);
      settle;
      check("t2_next_addr", 64'(io.imem_req_addr_o), 64'(held[63:32] + 32'd4));

      // flush while waiting on a slow response
      step(0, 0, 32'd0, 1, 0, 3, 32'hDEAD_BEEF);
      step(0, 1, 32'h8000_0103, 1, 1, 0, $urandom);
      drain_to_req;
      settle;
      check("t3_addr", 64'(io.imem_req_addr_o), 64'h8000_0100);
      to_out;
      settle;
      check("t3_pc", 64'(io.if_to_id_o[63:32]), 64'h8000_0100);
      step(0, 0, 32'd0, 0, 1, 0, $urandom);

      // flush in OUT with decode ready in the same cycle
      to_out;
      step(0, 1, 32'h1234_5679, 0, 1, 0, $urandom);
      settle;
      check("t4_if_valid", 64'(io.if_valid_o), 64'd0);
      check("t4_addr", 64'(io.imem_req_addr_o), 64'h1234_5678);

      // PC wrap-around
      step(0, 1, 32'hFFFF_FFFC, 0, 1, 0, $urandom);
      to_out;
      step(0, 0, 32'd0, 0, 1, 0, $urandom);
      settle;
      check("t5_wrap_addr", 64'(io.imem_req_addr_o), 64'd0);

      // reset while draining
      step(0, 1, 32'h0000_0040, 1, 0, 3, $urandom);
      settle;
      check("t6_drain", 64'(io.imem_resp_ready_o), 64'd1);
      step(1, 0, 32'd0, 0, 0, 0, $urandom);
      settle;
      check("t6_req_valid", 64'(io.imem_req_valid_o), 64'd1);
      check("t6_addr", 64'(io.imem_req_addr_o), 64'(RESET_PC));
      check("t6_if_valid", 64'(io.if_valid_o), 64'd0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 3))
            0:       rd = 32'hFFFF_FFFC;
            1:       rd = 32'hFFFF_FFF9;
            default: rd = $urandom;
         endcase
         step($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0, rd,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3), $urandom);
      end
      check("progress", 64'(n_xfer >= 100), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_ifu.md
Name: pipe_ifu

Overview:
- Instruction-fetch stage. It is the producer end of the IF→ID valid/ready interface that the decode stage consumes.
- Holds the PC and issues one instruction-memory request at a time. It captures the response and presents {pc, inst} to decode until accepted.
- On flush it redirects the PC and discards stale in-flight data.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high; sampled on the rising edge of clk_i.
- flush_i  in  1  pipeline flush/redirect request.
- redirect_pc_i  in  32  new fetch PC, used when flush_i=1.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  32  fetch address.
- imem_resp_valid_i  in  1  response data valid.
- imem_resp_ready_o  out  1  IFU accepts response.
- imem_resp_data_i  in  32  fetched instruction.
- if_valid_o  out  1  if_to_id_o holds a valid instruction.
- id_ready_i  in  1  decode accepts this cycle.
- if_to_id_o  out  64  ifToId_t {pc[31:0], inst[31:0]} from liang_pkg.

Behaviour:
- Registered state:
  - pc_q (32)
  - state ∈ {REQ, WAIT, OUT, DRAIN}
  - buffer {pc, inst}
- Reset (rst_i=1 at a clock edge, any state, mid-transaction included):
  - pc_q=RESET_PC, state=REQ, buffer=0.
  - Any pending response is abandoned; memory is required to be reset together.
- Outputs are decoded from state:
  - REQ: imem_req_valid_o=1, imem_req_addr_o=pc_q.
  - WAIT or DRAIN: imem_resp_ready_o=1.
  - OUT: if_valid_o=1, if_to_id_o=buffer.
  - All other cases: 0.
- Outputs during and just after reset (state REQ):
  - if_valid_o=0, imem_resp_ready_o=0, if_to_id_o=0.
  - imem_req_valid_o=1 with imem_req_addr_o=RESET_PC.
- Transitions (flush_i=0):
  - REQ: imem_req_ready_i=1 → WAIT; else stay.
  - WAIT: imem_resp_valid_i=1 → buffer={pc_q, imem_resp_data_i}, pc_q+=PC_STEP, → OUT; else stay.
  - OUT: id_ready_i=1 (fire) → REQ; else hold. buffer and if_valid_o must stay stable while stalled.
  - DRAIN: imem_resp_valid_i=1 → response discarded, → REQ; else stay.
- Latency:
  - Fixed 0 memory wait: request cycle, response cycle, present cycle, so one instruction per 3 cycles.
  - There is no overlap of request with OUT.
- Flush (flush_i=1) has priority over every transition:
  - pc_q ← {redirect_pc_i[31:2], 2'b00}; low bits are forced to zero.
  - The IF→ID handshake in a flush cycle does not count as a transfer, even if id_ready_i=1.
  - From OUT: buffer is invalidated → REQ.
  - From REQ with imem_req_ready_i=0: stay REQ (new addr next cycle).
  - From REQ with imem_req_ready_i=1: the request has been accepted → DRAIN.
  - From WAIT or DRAIN with imem_resp_valid_i=0 → DRAIN.
  - From WAIT or DRAIN with imem_resp_valid_i=1: the response is consumed and dropped → REQ.
- At most one outstanding request at all times. A response while in REQ or OUT is a protocol error; assert it in simulation.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Test Plan:
1. Reset, then memory always ready with 0-latency response, data=32'h0000_0013.
   → Request addresses are 80000000, 80000004, 80000008.
   → if_valid_o pulses with pc 80000000 / inst 00000013 on cycle 3 after reset release.
2. id_ready_i=0 for 5 cycles while in OUT.
   → if_valid_o=1 and if_to_id_o unchanged for all 5 cycles.
   → No new request issued; on id_ready_i=1, the next request addr=pc+4.
3. flush_i with redirect_pc_i=32'h8000_0103 while in WAIT (response delayed 3 cycles, data=DEADBEEF).
   → DEADBEEF is never presented.
   → The next request addr is 80000100, and its response is presented with pc 80000100.
4. flush_i in OUT with id_ready_i=1 in the same cycle.
   → No transfer counted; if_valid_o=0 next cycle.
   → Next request addr = redirect_pc_i.
5. Redirect to 32'hFFFF_FFFC, fetch completes.
   → Following request addr = 32'h0000_0000.
6. rst_i asserted while in DRAIN.
   → Next cycle: state REQ, if_valid_o=0, imem_req_addr_o=RESET_PC.
